mem_bank_ctrl: RTL

Single-owner controller that sequences one mem_bank instance and shares it between a write requester and a read requester, e.g. the AXI write and read channel front-ends. It arbitrates round-robin and converts valid/ready request/response handshakes into bank cs/wstrb/row_addr cycles. It honours the bank's one-cycle registered read latency and its tri-stated rdata, which is only driven while cs is high.

---
 rtl/mem_bank_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_bank_ctrl.sv
// rtl/mem_bank_ctrl.sv - round-robin write/read sequencer sharing one mem_bank
module mem_bank_ctrl #(
  parameter int SIZE = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_req_valid,
  output logic                     wr_req_ready,
  input  logic [11:0]              wr_req_addr,
  input  logic [(2**SIZE)*8-1:0]   wr_req_data,
  input  logic [2**SIZE-1:0]       wr_req_strb,
  output logic                     wr_rsp_valid,
  input  logic                     wr_rsp_ready,
  input  logic                     rd_req_valid,
  output logic                     rd_req_ready,
  input  logic [11:0]              rd_req_addr,
  output logic                     rd_rsp_valid,
  input  logic                     rd_rsp_ready,
  output logic [(2**SIZE)*8-1:0]   rd_rsp_data,
  output logic                     bank_cs,
  output logic                     bank_we,
  output logic [11-SIZE:0]         bank_row_addr,
  output logic [(2**SIZE)*8-1:0]   bank_wdata,
  output logic [2**SIZE-1:0]       bank_wstrb,
  input  logic [(2**SIZE)*8-1:0]   bank_rdata
);

  localparam int NB = 2**SIZE;
  localparam int DW = NB*8;
  localparam int RW = 12-SIZE;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RSP, S_RD_ISSUE, S_RD_CAP, S_RD_RSP
  } state_t;

  state_t          state_q, state_d;
  logic            rr_rd_q, rr_rd_d;   // 1: next contested grant goes to read
  logic            grant_wr, grant_rd;
  logic            bank_cs_q, bank_cs_d;
  logic            bank_we_q, bank_we_d;
  logic [RW-1:0]   bank_row_addr_q, bank_row_addr_d;
  logic [DW-1:0]   bank_wdata_q, bank_wdata_d;
  logic [NB-1:0]   bank_wstrb_q, bank_wstrb_d;
  logic            wr_rsp_valid_q, wr_rsp_valid_d;
  logic            rd_rsp_valid_q, rd_rsp_valid_d;
  logic [DW-1:0]   rd_rsp_data_q, rd_rsp_data_d;

  // Byte-offset address bits select nothing: the bank always works on whole rows.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{wr_req_addr[SIZE-1:0], rd_req_addr[SIZE-1:0]};

  // Next-state, arbitration and next values of every registered output.
  always_comb begin
    state_d         = state_q;
    rr_rd_d         = rr_rd_q;
    grant_wr        = 1'b0;
    grant_rd        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_req_valid && rd_req_valid) begin
          grant_rd = rr_rd_q;
          grant_wr = !rr_rd_q;
          rr_rd_d  = !rr_rd_q;
        end else begin
          grant_rd = rd_req_valid;
          grant_wr = wr_req_valid;
        end
        if (grant_wr) begin
          state_d = S_WR;
        end else if (grant_rd) begin
          state_d = S_RD_ISSUE;
        end
      end
      S_WR:       state_d = S_WR_RSP;
      S_WR_RSP:   if (wr_rsp_ready) state_d = S_IDLE;
      S_RD_ISSUE: state_d = S_RD_CAP;
      S_RD_CAP:   state_d = S_RD_RSP;
      S_RD_RSP:   if (rd_rsp_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Bank is selected from issue through capture so rdata is driven while sampled.
    bank_cs_d       = (state_d == S_WR) || (state_d == S_RD_ISSUE) || (state_d == S_RD_CAP);
    bank_we_d       = (state_d == S_WR);
    // Accept is always followed by WR, so the strobes only exist for that one cycle.
    bank_wstrb_d    = grant_wr ? wr_req_strb : '0;
    bank_wdata_d    = grant_wr ? wr_req_data : bank_wdata_q;
    bank_row_addr_d = grant_wr ? wr_req_addr[11:SIZE] :
                      grant_rd ? rd_req_addr[11:SIZE] : bank_row_addr_q;
    wr_rsp_valid_d  = (state_d == S_WR_RSP);
    rd_rsp_valid_d  = (state_d == S_RD_RSP);
    rd_rsp_data_d   = (state_q == S_RD_CAP) ? bank_rdata : rd_rsp_data_q;
  end

  // State, round-robin pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      rr_rd_q         <= 1'b1;
      bank_cs_q       <= 1'b0;
      bank_we_q       <= 1'b0;
      bank_row_addr_q <= '0;
      bank_wdata_q    <= '0;
      bank_wstrb_q    <= '0;
      wr_rsp_valid_q  <= 1'b0;
      rd_rsp_valid_q  <= 1'b0;
      rd_rsp_data_q   <= '0;
    end else begin
      state_q         <= state_d;
      rr_rd_q         <= rr_rd_d;
      bank_cs_q       <= bank_cs_d;
      bank_we_q       <= bank_we_d;
      bank_row_addr_q <= bank_row_addr_d;
      bank_wdata_q    <= bank_wdata_d;
      bank_wstrb_q    <= bank_wstrb_d;
      wr_rsp_valid_q  <= wr_rsp_valid_d;
      rd_rsp_valid_q  <= rd_rsp_valid_d;
      rd_rsp_data_q   <= rd_rsp_data_d;
    end
  end

  // Ready is masked during reset so nothing looks accepted while state is being cleared.
  assign wr_req_ready  = grant_wr && !rst;
  assign rd_req_ready  = grant_rd && !rst;
  assign wr_rsp_valid  = wr_rsp_valid_q;
  assign rd_rsp_valid  = rd_rsp_valid_q;
  assign rd_rsp_data   = rd_rsp_data_q;
  assign bank_cs       = bank_cs_q;
  assign bank_we       = bank_we_q;
  assign bank_row_addr = bank_row_addr_q;
  assign bank_wdata    = bank_wdata_q;
  assign bank_wstrb    = bank_wstrb_q;

endmodule
